// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one registered write-only bus between NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to add a stall watchdog that drops stuck beats and raises timeout_err.
module bus_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      bus_valid,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  input  logic                      bus_ready,
  output logic [ID_W-1:0]           grant_id,
`ifdef ARB_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  output logic [15:0]               txn_count
);

  logic            load;
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] last;
  logic            drop_beat;

  assign load = !bus_valid || bus_ready;

  // NOTE: every variable driven here gets a default first, so no path leaves a latch behind.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    req_ready = '0;
    // Search starts one past the previous winner, so the last owner has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    if (rst_n && load && win_found)
      req_ready[win_id] = 1'b1;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] stall_cnt;

  assign drop_beat = bus_valid && !bus_ready && (stall_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (load)
        stall_cnt <= '0;
      else if (bus_valid && !bus_ready)
        stall_cnt <= stall_cnt + 1'b1;
      if (drop_beat)
        timeout_err <= 1'b1;
    end
  end
`else
  assign drop_beat = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      grant_id  <= '0;
      last      <= ID_W'(NUM_REQ - 1);
      txn_count <= '0;
    end else begin
      if (bus_valid && bus_ready)
        txn_count <= txn_count + 16'd1;
      if (load) begin
        if (win_found) begin
          bus_valid <= 1'b1;
          bus_addr  <= req_addr[int'(win_id)*ADDR_W +: ADDR_W];
          bus_wdata <= req_wdata[int'(win_id)*DATA_W +: DATA_W];
          grant_id  <= win_id;
          last      <= win_id;
        end else begin
          bus_valid <= 1'b0;
        end
      end else if (drop_beat) begin
        // A timed-out beat is discarded without counting; arbitration restarts next cycle.
        bus_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter (NUM_REQ=4, 32-bit address/data).
module tb_bus_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      bus_valid;
  logic [ADDR_W-1:0]         bus_addr;
  logic [DATA_W-1:0]         bus_wdata;
  logic                      bus_ready;
  logic [1:0]                grant_id;
  logic [15:0]               txn_count;
`ifdef ARB_TIMEOUT_EN
  logic                      timeout_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .grant_id(grant_id),
`ifdef ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .txn_count(txn_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic v, input logic [1:0] g,
                         input logic [31:0] a, input logic [15:0] t);
    chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(v));
    chk({tag, ".grant_id"},  32'(grant_id),  32'(g));
    chk({tag, ".bus_addr"},  bus_addr,       a);
    chk({tag, ".txn_count"}, 32'(txn_count), 32'(t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with requests already pending to show req_ready stays low in reset.
    rst_n     = 1'b0;
    bus_ready = 1'b0;
    req_valid = 4'b1111;
    req_addr  = '0;
    req_wdata = '0;
    #3;
    chk("reset.req_ready", 32'(req_ready), 32'h0);
    chk_bus("reset", 1'b0, 2'd0, 32'h0, 16'h0);
    chk("reset.bus_wdata", bus_wdata, 32'h0);
    req_valid = 4'b0000;
    #9;
    rst_n = 1'b1;

    // Single request from requester 0.
    tick();
    req_addr[0 +: 32]  = 32'h10;
    req_wdata[0 +: 32] = 32'hA5;
    req_valid = 4'b0001;
    bus_ready = 1'b1;
    #1;
    chk("single.req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single.ready_drop", 32'(req_ready), 32'h0);
    chk_bus("single.beat", 1'b1, 2'd0, 32'h10, 16'd0);
    chk("single.bus_wdata", bus_wdata, 32'hA5);
    tick();
    chk_bus("single.done", 1'b0, 2'd0, 32'h10, 16'd1);

    // Fresh reset, then all four requesting: strict rotation with no bubbles.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*32 +: 32]  = 32'h100 + 32'(i);
      req_wdata[i*32 +: 32] = 32'hD0 + 32'(i);
    end
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr%0d.req_ready", i), 32'(req_ready), 32'(1 << (i % 4)));
      tick();
      chk_bus($sformatf("rr%0d", i), 1'b1, 2'(i % 4), 32'h100 + 32'(i % 4), 16'(i));
    end
    req_valid = 4'b0000;
    tick();
    chk_bus("rr.end", 1'b0, 2'd3, 32'h103, 16'd8);

    // Stall: outputs hold and req_ready stays low; next grant rotates to 2.
    req_valid = 4'b0101;
    bus_ready = 1'b0;
    #1;
    chk("stall.first_ready", 32'(req_ready), 32'h1);
    tick();
    chk_bus("stall.load", 1'b1, 2'd0, 32'h100, 16'd8);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d.req_ready", i), 32'(req_ready), 32'h0);
      tick();
      chk_bus($sformatf("stall%0d", i), 1'b1, 2'd0, 32'h100, 16'd8);
    end
    bus_ready = 1'b1;
    #1;
    chk("stall.release_ready", 32'(req_ready), 32'h4);
    tick();
    chk_bus("stall.next", 1'b1, 2'd2, 32'h102, 16'd9);
    req_valid = 4'b0000;
    tick();
    chk_bus("stall.done", 1'b0, 2'd2, 32'h102, 16'd10);

    // Streaming single requester up to 0xFFFE, then three transfers across the wrap.
    req_valid = 4'b0001;
    repeat (65525) @(posedge clk);
    #1;
    chk_bus("wrap.pre", 1'b1, 2'd0, 32'h100, 16'hFFFE);
    tick();
    chk("wrap.ffff", 32'(txn_count), 32'hFFFF);
    tick();
    chk("wrap.0000", 32'(txn_count), 32'h0000);
    tick();
    chk("wrap.0001", 32'(txn_count), 32'h0001);

    // Asynchronous reset while a beat is stalled; requester 0 regains priority.
    bus_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("areset.pre_valid", 32'(bus_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("areset.bus_valid", 32'(bus_valid), 32'h0);
    chk("areset.txn_count", 32'(txn_count), 32'h0);
    chk("areset.req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("areset.prio_ready", 32'(req_ready), 32'h1);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    chk_bus("areset.beat", 1'b1, 2'd0, 32'h100, 16'd0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: beat dropped on the 16th stalled edge, uncounted, error sticky.
    chk("to.err_init", 32'(timeout_err), 32'h0);
    for (int i = 1; i < 16; i++) tick();
    chk("to.still_valid", 32'(bus_valid), 32'h1);
    chk("to.err_pre", 32'(timeout_err), 32'h0);
    tick();
    chk("to.dropped", 32'(bus_valid), 32'h0);
    chk("to.err", 32'(timeout_err), 32'h1);
    chk("to.txn", 32'(txn_count), 32'h0);
    req_valid = 4'b0010;
    #1;
    chk("to.resume_ready", 32'(req_ready), 32'h2);
    tick();
    chk("to.resume_grant", 32'(grant_id), 32'h1);
    chk("to.err_sticky", 32'(timeout_err), 32'h1);
`else
    // Without the watchdog the stalled beat waits indefinitely.
    repeat (20) @(posedge clk);
    #1;
    chk("nowd.bus_valid", 32'(bus_valid), 32'h1);
    chk("nowd.txn", 32'(txn_count), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Shares one write-only bus (addr/wdata/valid, ready back-pressure) between NUM_REQ requesters using round-robin arbitration.
- Sits between the bus_if-style master ports and the shared slave-side bus.
- Registered output stage gives one transfer per cycle at full throughput.
- Keeps a wrapping count of completed transfers for debug.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: write-data width.
- TIMEOUT_CYC, 16: stall limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready  out  NUM_REQ  one-hot accept strobe, combinational.
- bus_valid  out  1  shared bus request, registered.
- bus_addr  out  ADDR_W  registered address.
- bus_wdata  out  DATA_W  registered write data.
- bus_ready  in  1  slave accept.
- grant_id  out  $clog2(NUM_REQ)  index of the requester owning the current bus_valid beat.
- txn_count  out  16  completed transfers, wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset is asynchronous and active-low; clk is the single clock.
- Reset values:
  - bus_valid=0, bus_addr=0, bus_wdata=0, grant_id=0, txn_count=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0 while rst_n=0.
- Load enable: load = !bus_valid || bus_ready. The output register can take a new beat this cycle.
- Arbitration (combinational) when load=1 and |req_valid:
  - Winner w is the first set bit of req_valid searching from (last+1) mod NUM_REQ upward, wrapping.
  - req_ready[w]=1, and no other req_ready bit is high.
  - At posedge: bus_valid<=1, bus_addr<=req_addr[w], bus_wdata<=req_wdata[w], grant_id<=w, last<=w.
- When load=1 and req_valid==0: at posedge bus_valid<=0. bus_addr, bus_wdata and grant_id hold their values.
- When load=0: req_ready=0, and all output registers hold.
- Latency: a request accepted (req_valid[i]&&req_ready[i]) in cycle N appears on the bus in cycle N+1.
- Throughput: back-to-back beats with no bubble while bus_ready=1.
- Completion: each cycle with bus_valid&&bus_ready increments txn_count by 1, with modulo-2^16 wrap.
- Requester contract: hold req_valid, req_addr and req_wdata stable until accepted. The block does not check this.
- Fairness: with all requesters continuously requesting, grants follow the strict rotation 0,1,..,NUM_REQ-1,0. Maximum wait is NUM_REQ-1 grants.
- Single requester: the same requester can be granted on consecutive cycles.
- Simultaneous events: completion of the current beat and acceptance of the next beat happen in the same cycle. txn_count increments and the new beat loads.
- Reset mid-operation: asserting rst_n drops bus_valid immediately (asynchronously). The in-flight beat is lost and not counted.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Adds output port timeout_err (1 bit, sticky, reset 0) and an internal stall counter.
  - The stall counter clears on any load and increments each cycle with bus_valid=1 && bus_ready=0.
  - When the counter reaches TIMEOUT_CYC-1 while still stalled:
    - at that posedge the beat is dropped (bus_valid<=0);
    - timeout_err<=1;
    - txn_count does not increment.
  - Arbitration resumes on the next cycle.
  - timeout_err clears only on reset.
- Undefined: no port and no counter; the block waits on bus_ready indefinitely.

Test Plan:
- Reset, then req_valid=4'b0001 with addr 0x10 / wdata 0xA5, bus_ready=1 -> req_ready[0] pulses one cycle; next cycle bus_valid=1, bus_addr=0x10, grant_id=0; txn_count=1 after the beat.
- req_valid=4'b1111 held, bus_ready=1, 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3; no bubbles; txn_count=8.
- req_valid=4'b0101, bus_ready=0 for 3 cycles, then 1 -> bus_addr and grant_id stable during the stall; req_ready all 0 during the stall; next grant is 2.
- txn_count preloaded to 0xFFFE by running transfers, then 3 transfers -> 0xFFFF, 0x0000, 0x0001.
- rst_n pulled low while bus_valid=1 && bus_ready=0 -> bus_valid=0 with no clock edge; after release, requester 0 has priority again.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=16: bus_ready held 0 -> beat dropped after the 16th stall cycle; timeout_err=1; txn_count unchanged.
